// File: rtl/carrier_loop_filter_pkg.sv
// Shared constants and types for the carrier loop filter.
// Holds the default widths, acquisition-control bit positions, lock states and 32-bit saturation bounds.
package carrier_loop_pkg;

  localparam int DEF_ERR_W = 12;
  localparam int DEF_OUT_W = 32;

  localparam int ACQ_FREEZE_BIT = 0;
  localparam int ACQ_NOLEAD_BIT = 1;

  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/carrier_loop_filter_gain_scale.sv
// Combinational gain stage: signed error times unsigned mantissa, shifted left by the exponent.
// The result saturates to the signed 32-bit range.
module loop_gain_scale
  import carrier_loop_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ERR_W-1:0] err,
  input  logic        [7:0]       gainMan,
  input  logic        [4:0]       gainExp,
  output logic signed [OUT_W-1:0] term
);

  localparam int PROD_W = ERR_W + 9;
  localparam logic signed [63:0] SAT_HI = 64'(SAT_MAX);
  localparam logic signed [63:0] SAT_LO = 64'(SAT_MIN);

  function automatic logic signed [OUT_W-1:0] sat32(input logic signed [63:0] x);
    if (x > SAT_HI)
      return OUT_W'(SAT_HI);
    else if (x < SAT_LO)
      return OUT_W'(SAT_LO);
    else
      return x[OUT_W-1:0];
  endfunction

  logic signed [PROD_W-1:0] prod;
  logic signed [63:0]       shifted;

  always_comb begin
    prod    = PROD_W'(err) * PROD_W'($signed({1'b0, gainMan}));
    shifted = {{(64-PROD_W){prod[PROD_W-1]}}, prod} << gainExp;
    term    = sat32(shifted);
  end

endmodule

// File: rtl/carrier_loop_filter.sv
// Proportional-plus-integral carrier loop filter with a hysteretic lock detector.
// Four register stages: error conditioning, gain scaling, integration, output summation.
module carrier_loop_filter
  import carrier_loop_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clkEn,
  input  logic signed [ERR_W-1:0] error,
  input  logic                    zeroError,
  input  logic                    invertError,
  input  logic                    clearAccum,
  input  logic        [1:0]       acqTrackControl,
  input  logic        [4:0]       leadExp,
  input  logic        [4:0]       lagExp,
  input  logic        [7:0]       leadMan,
  input  logic        [7:0]       lagMan,
  input  logic signed [OUT_W-1:0] upperLimit,
  input  logic signed [OUT_W-1:0] lowerLimit,
  input  logic        [15:0]      lockCount,
  input  logic        [11:0]      syncThreshold,
  output logic signed [OUT_W-1:0] loopOut,
  output logic                    outValid,
  output logic signed [OUT_W-1:0] lagAccum,
  output logic                    lockStatus
);

  localparam logic signed [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic signed [ERR_W-1:0] ERR_MAX = ~ERR_MIN;

  function automatic logic signed [ERR_W-1:0] condition(input logic signed [ERR_W-1:0] e,
                                                         input logic zero, input logic inv);
    if (zero)
      return '0;
    else if (inv)
      return (e == ERR_MIN) ? ERR_MAX : -e;
    else
      return e;
  endfunction

  // An inverted limit pair resolves to upperLimit above it and lowerLimit otherwise.
  function automatic logic signed [OUT_W-1:0] clamp(input logic signed [OUT_W:0]   x,
                                                     input logic signed [OUT_W-1:0] hi,
                                                     input logic signed [OUT_W-1:0] lo);
    logic signed [OUT_W:0] hiX;
    logic signed [OUT_W:0] loX;
    hiX = {hi[OUT_W-1], hi};
    loX = {lo[OUT_W-1], lo};
    if (x > hiX)
      return hi;
    else if (x < loX)
      return lo;
    else
      return x[OUT_W-1:0];
  endfunction

  logic                    vld_p1, vld_p2, vld_p3;
  logic signed [ERR_W-1:0] condErr_p1;
  logic        [ERR_W-1:0] mag_p1;
  logic                    inBand_p1, inBand_p2;
  logic signed [OUT_W-1:0] leadTerm_p1, lagTerm_p1;
  logic signed [OUT_W-1:0] leadTerm_p2, lagTerm_p2, leadTerm_p3;
  logic signed [OUT_W:0]   accSum, outSum;
  logic        [15:0]      lockCnt, lockCntNext;
  lock_state_e             lockState, lockStateNext;

  // Stage 1: condition the incoming error.
  always_ff @(posedge clk) begin
    if (clkEn)
      condErr_p1 <= condition(error, zeroError, invertError);
  end

  // Stage 2: scale the conditioned error and compute the in-band flag.
  loop_gain_scale #(.ERR_W(ERR_W), .OUT_W(OUT_W)) u_lead (
    .err(condErr_p1), .gainMan(leadMan), .gainExp(leadExp), .term(leadTerm_p1)
  );

  loop_gain_scale #(.ERR_W(ERR_W), .OUT_W(OUT_W)) u_lag (
    .err(condErr_p1), .gainMan(lagMan), .gainExp(lagExp), .term(lagTerm_p1)
  );

  always_comb begin
    mag_p1    = condErr_p1[ERR_W-1] ? $unsigned(-condErr_p1) : $unsigned(condErr_p1);
    inBand_p1 = (mag_p1 < syncThreshold);
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      leadTerm_p2 <= acqTrackControl[ACQ_NOLEAD_BIT] ? '0 : leadTerm_p1;
      lagTerm_p2  <= lagTerm_p1;
      inBand_p2   <= inBand_p1;
    end
    if (vld_p2)
      leadTerm_p3 <= leadTerm_p2;
  end

  // Stage 3: integrator update and lock counter; stage 4: output sum.
  always_comb begin
    accSum = {lagAccum[OUT_W-1], lagAccum} + {lagTerm_p2[OUT_W-1], lagTerm_p2};
    outSum = {leadTerm_p3[OUT_W-1], leadTerm_p3} + {lagAccum[OUT_W-1], lagAccum};
  end

  always_comb begin
    lockCntNext   = lockCnt;
    lockStateNext = lockState;
    if (lockCount == 16'd0) begin
      lockCntNext   = '0;
      lockStateNext = UNLOCKED;
    end else begin
      if (inBand_p2)
        lockCntNext = (lockCnt >= lockCount) ? lockCount : lockCnt + 16'd1;
      else
        lockCntNext = (lockCnt == 16'd0) ? 16'd0 : lockCnt - 16'd1;
      if (lockCntNext > lockCount)
        lockCntNext = lockCount;
      if (lockState == UNLOCKED && lockCntNext == lockCount)
        lockStateNext = LOCKED;
      else if (lockState == LOCKED && lockCntNext == 16'd0)
        lockStateNext = UNLOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      outValid  <= 1'b0;
      lagAccum  <= '0;
      loopOut   <= '0;
      lockCnt   <= '0;
      lockState <= UNLOCKED;
    end else begin
      vld_p1   <= clkEn;
      vld_p2   <= vld_p1;
      vld_p3   <= vld_p2;
      outValid <= vld_p3;
      if (clearAccum)
        lagAccum <= '0;
      else if (vld_p2 && !acqTrackControl[ACQ_FREEZE_BIT])
        lagAccum <= clamp(accSum, upperLimit, lowerLimit);
      if (vld_p3)
        loopOut <= clamp(outSum, upperLimit, lowerLimit);
      if (vld_p2) begin
        lockCnt   <= lockCntNext;
        lockState <= lockStateNext;
      end
    end
  end

  assign lockStatus = (lockState == LOCKED);

endmodule

// File: tb/tb_carrier_loop_filter.sv
// Directed bench for carrier_loop_filter: single-sample vector table plus multi-cycle sequences.
module tb_carrier_loop_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic               clkEn;
  logic signed [11:0] error;
  logic               zeroError, invertError, clearAccum;
  logic        [1:0]  acqTrackControl;
  logic        [4:0]  leadExp, lagExp;
  logic        [7:0]  leadMan, lagMan;
  logic signed [31:0] upperLimit, lowerLimit;
  logic        [15:0] lockCount;
  logic        [11:0] syncThreshold;
  logic signed [31:0] loopOut, lagAccum;
  logic               outValid, lockStatus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carrier_loop_filter dut (
    .clk(clk), .reset(reset), .clkEn(clkEn), .error(error),
    .zeroError(zeroError), .invertError(invertError), .clearAccum(clearAccum),
    .acqTrackControl(acqTrackControl), .leadExp(leadExp), .lagExp(lagExp),
    .leadMan(leadMan), .lagMan(lagMan), .upperLimit(upperLimit), .lowerLimit(lowerLimit),
    .lockCount(lockCount), .syncThreshold(syncThreshold),
    .loopOut(loopOut), .outValid(outValid), .lagAccum(lagAccum), .lockStatus(lockStatus)
  );

  typedef struct {
    logic signed [11:0] err;
    logic               inv;
    logic               zero;
    logic        [1:0]  acq;
    logic        [7:0]  leadM;
    logic        [4:0]  leadE;
    logic        [7:0]  lagM;
    logic        [4:0]  lagE;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] wantOut;
    logic signed [31:0] wantAcc;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  logic signed [11:0] lockErrs[8];

  initial begin
    vecs[0]  = '{12'sd10,    1'b0, 1'b0, 2'b00, 8'd1,   5'd4,  8'd0, 5'd0, 32'sd1000000, -32'sd1000000, 32'sd160, 32'sd0};
    vecs[1]  = '{12'sd10,    1'b1, 1'b0, 2'b00, 8'd1,   5'd4,  8'd0, 5'd0, 32'sd1000000, -32'sd1000000, -32'sd160, 32'sd0};
    vecs[2]  = '{12'sd2047,  1'b0, 1'b0, 2'b00, 8'd255, 5'd31, 8'd0, 5'd0, 32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF, 32'sd0};
    vecs[3]  = '{-12'sd2048, 1'b1, 1'b0, 2'b00, 8'd255, 5'd31, 8'd0, 5'd0, 32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF, 32'sd0};
    vecs[4]  = '{-12'sd2048, 1'b0, 1'b0, 2'b00, 8'd255, 5'd31, 8'd0, 5'd0, 32'sh7FFFFFFF, 32'sh80000000, 32'sh80000000, 32'sd0};
    vecs[5]  = '{12'sd500,   1'b0, 1'b1, 2'b00, 8'd1,   5'd0,  8'd1, 5'd0, 32'sd1000000, -32'sd1000000, 32'sd0, 32'sd0};
    vecs[6]  = '{12'sd10,    1'b0, 1'b0, 2'b10, 8'd1,   5'd4,  8'd1, 5'd0, 32'sd1000000, -32'sd1000000, 32'sd10, 32'sd10};
    vecs[7]  = '{12'sd3,     1'b0, 1'b0, 2'b00, 8'd2,   5'd1,  8'd3, 5'd2, 32'sd1000000, -32'sd1000000, 32'sd48, 32'sd36};
    vecs[8]  = '{12'sd5,     1'b0, 1'b0, 2'b00, 8'd1,   5'd0,  8'd0, 5'd0, -32'sd10, 32'sd10, -32'sd10, -32'sd10};
    vecs[9]  = '{-12'sd20,   1'b0, 1'b0, 2'b00, 8'd5,   5'd0,  8'd0, 5'd0, 32'sd100, -32'sd50, -32'sd50, 32'sd0};
    vecs[10] = '{12'sd7,     1'b0, 1'b0, 2'b01, 8'd1,   5'd0,  8'd1, 5'd0, 32'sd1000000, -32'sd1000000, 32'sd7, 32'sd0};

    reset = 1'b1; clkEn = 1'b1; error = 12'sd100;
    zeroError = 1'b0; invertError = 1'b0; clearAccum = 1'b0; acqTrackControl = 2'b00;
    leadExp = 5'd0; lagExp = 5'd0; leadMan = 8'd0; lagMan = 8'd0;
    upperLimit = 32'sd1000000; lowerLimit = -32'sd1000000;
    lockCount = 16'd0; syncThreshold = 12'd0;

    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("reset%0d loopOut", i), loopOut, 32'd0);
      chk($sformatf("reset%0d lagAccum", i), lagAccum, 32'd0);
      chk($sformatf("reset%0d vld/lock", i), {30'd0, outValid, lockStatus}, 32'd0);
    end
    reset = 1'b0;
    step();
    chk("post-reset loopOut", loopOut, 32'd0);
    chk("post-reset vld/lock", {30'd0, outValid, lockStatus}, 32'd0);
    clkEn = 1'b0;
    for (int i = 0; i < 4; i++) step();

    for (int v = 0; v < 11; v++) begin
      error = vecs[v].err; invertError = vecs[v].inv; zeroError = vecs[v].zero;
      acqTrackControl = vecs[v].acq; leadMan = vecs[v].leadM; leadExp = vecs[v].leadE;
      lagMan = vecs[v].lagM; lagExp = vecs[v].lagE;
      upperLimit = vecs[v].hi; lowerLimit = vecs[v].lo;
      clearAccum = 1'b1;
      step();
      clearAccum = 1'b0;
      clkEn = 1'b1;
      step();
      clkEn = 1'b0;
      step();
      step();
      chk($sformatf("vec%0d early outValid", v), {31'd0, outValid}, 32'd0);
      step();
      chk($sformatf("vec%0d outValid", v), {31'd0, outValid}, 32'd1);
      chk($sformatf("vec%0d loopOut", v), loopOut, vecs[v].wantOut);
      chk($sformatf("vec%0d lagAccum", v), lagAccum, vecs[v].wantAcc);
      step();
      chk($sformatf("vec%0d strobe width", v), {31'd0, outValid}, 32'd0);
    end
    invertError = 1'b0; zeroError = 1'b0; acqTrackControl = 2'b00;

    // Integrator ramp, freeze and clear.
    leadMan = 8'd0; lagMan = 8'd2; lagExp = 5'd0;
    upperLimit = 32'sd1000000; lowerLimit = -32'sd1000000;
    clearAccum = 1'b1; step(); clearAccum = 1'b0;
    error = 12'sd5; clkEn = 1'b1;
    step(); step();
    step(); chk("integ 10", lagAccum, 32'sd10);
    step(); chk("integ 20", lagAccum, 32'sd20);
    clkEn = 1'b0;
    step(); chk("integ 30", lagAccum, 32'sd30);
    step(); chk("integ 40", lagAccum, 32'sd40);
    acqTrackControl = 2'b01; clkEn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    clkEn = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("freeze lagAccum", lagAccum, 32'sd40);
    chk("freeze loopOut", loopOut, 32'sd40);
    acqTrackControl = 2'b00; clearAccum = 1'b1;
    step(); chk("clearAccum", lagAccum, 32'sd0);
    clearAccum = 1'b0;

    // Integrator clamping.
    upperLimit = 32'sd100; lowerLimit = -32'sd50; lagMan = 8'd1;
    clkEn = 1'b1; error = 12'sd60;
    step(); step();
    step(); chk("limit 60", lagAccum, 32'sd60);
    error = -12'sd200;
    step(); chk("limit 100a", lagAccum, 32'sd100);
    clkEn = 1'b0;
    step(); chk("limit 100b", lagAccum, 32'sd100);
    step(); chk("limit -50", lagAccum, -32'sd50);
    step(); step();

    // Reset mid-operation discards the in-flight sample.
    upperLimit = 32'sd1000000; lowerLimit = -32'sd1000000;
    leadMan = 8'd1; leadExp = 5'd0; lagMan = 8'd1;
    clearAccum = 1'b1; step(); clearAccum = 1'b0;
    clkEn = 1'b1; error = 12'sd50;
    step(); clkEn = 1'b0;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midreset%0d outValid", i), {31'd0, outValid}, 32'd0);
      chk($sformatf("midreset%0d lagAccum", i), lagAccum, 32'd0);
    end

    // Lock detector hysteresis, then disabled with lockCount=0.
    lockErrs = '{12'sd3, 12'sd3, 12'sd3, 12'sd3, 12'sd100, 12'sd100, 12'sd100, 12'sd100};
    syncThreshold = 12'd16;
    for (int pass = 0; pass < 2; pass++) begin
      lockCount = (pass == 0) ? 16'd4 : 16'd0;
      for (int k = 0; k < 10; k++) begin
        if (k < 8) begin
          clkEn = 1'b1;
          error = (pass == 0) ? lockErrs[k] : 12'sd3;
        end else begin
          clkEn = 1'b0;
        end
        step();
        chk($sformatf("lock p%0d edge%0d", pass, k), {31'd0, lockStatus},
            {31'd0, (pass == 0) && (k >= 5) && (k <= 8)});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carrier_loop_filter.md
Name: carrier_loop_filter

Overview:
Proportional-plus-integral carrier loop filter with lock detector, driven by the carrier-loop control register bank. It takes the phase/frequency discriminator error, scales it with the lead (proportional) and lag (integral) gains, integrates and limits the lag path, and produces the NCO frequency-control word. It returns the integrator value and the lock status to the register bank for readback.

Parameters:
ERR_W, 12, discriminator error width (signed)
OUT_W, 32, accumulator, limit and output width (signed)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clkEn  in  1  sample strobe; error is valid when high
error  in  ERR_W  signed discriminator error
zeroError  in  1  force conditioned error to 0
invertError  in  1  negate conditioned error
clearAccum  in  1  level; hold integrator at 0
acqTrackControl  in  2  bit0 freezes the integrator; bit1 zeroes the lead term
leadExp, lagExp  in  5  gain exponents (left shift 0..31)
leadMan, lagMan  in  8  unsigned gain mantissas
upperLimit, lowerLimit  in  OUT_W  signed clamp limits
lockCount  in  16  lock-detector hysteresis depth
syncThreshold  in  12  in-band magnitude threshold
loopOut  out  OUT_W  signed NCO control word
outValid  out  1  one-cycle strobe, loopOut updated
lagAccum  out  OUT_W  signed integrator value
lockStatus  out  1  carrier lock

Behaviour:
- Reset: loopOut=0, lagAccum=0, outValid=0, lockStatus=0, lock counter=0, state UNLOCKED, pipeline valids=0. Reset applied mid-operation discards all in-flight samples.
- Pipeline advances only for valid samples. v0=clkEn, v1, v2, v3=outValid. An error sampled at edge N gives outValid at edge N+3.
- S1 (edge N): condErr = zeroError ? 0 : (invertError ? -error : error). Negating -2048 saturates to +2047.
- S2: leadTerm = sat32((condErr*leadMan) << leadExp). lagTerm is computed the same way. The product is 21-bit signed; it is sign-extended to 64 bits before the shift, then saturated to [0x80000000, 0x7FFFFFFF]. If acqTrackControl[1]=1, leadTerm=0.
- S3: integrator update. Precedence: clearAccum (lagAccum<=0 on every clock, regardless of valid) > acqTrackControl[0] (hold) > lagAccum <= clamp(lagAccum + lagTerm). The sum is computed at 33 bits.
- S4: loopOut <= clamp(leadTerm_d + lagAccum), using the updated accumulator and a 33-bit sum. outValid pulses for 1 clock.
- clamp(x): if x>upperLimit then upperLimit, else if x<lowerLimit then lowerLimit, else x. If lowerLimit>upperLimit, the result is upperLimit for x>upperLimit and otherwise lowerLimit; no error is flagged.
- Lock detector runs on the S1 output, on valid samples only:
  - inBand = |condErr| < syncThreshold (unsigned 12-bit magnitude; |-2048| = 2048).
  - inBand: counter = min(counter+1, lockCount). Otherwise: counter = max(counter-1, 0).
  - UNLOCKED->LOCKED when the new counter == lockCount. LOCKED->UNLOCKED when the new counter == 0.
  - lockStatus is registered with the counter: it changes at edge N+2 for a sample taken at edge N.
  - lockCount==0: counter forced to 0, state UNLOCKED.
  - If lockCount is lowered below the counter, the counter clamps to lockCount on the next valid sample.
- clkEn may be high on every clock; back-to-back samples are fully pipelined with no stalls. The integrator feedback is a single-cycle path.
- Register inputs are treated as quasi-static. They are sampled directly with no resynchronisation.

Decomposition:
- Package carrier_loop_pkg: ERR_W/OUT_W defaults, ACQ_FREEZE_BIT=0, ACQ_NOLEAD_BIT=1, lock state encoding (UNLOCKED=0, LOCKED=1), SAT_MAX/SAT_MIN constants.
- Sub-module loop_gain_scale: combinational error x mantissa << exponent with 32-bit saturation. It is instantiated twice (lead, lag). Clamp and lock detector stay inline.

Test Plan:
- Reset held 5 clocks with clkEn=1, error=100 -> loopOut=0, lagAccum=0, outValid=0, lockStatus=0 throughout and 1 clock after release.
- Lead path only: leadMan=1, leadExp=4, lagMan=0, limits +/-1e6, single clkEn with error=+10 -> outValid exactly 3 clocks later, loopOut=160, lagAccum=0. invertError=1 -> loopOut=-160.
- Integrator: lagMan=2, lagExp=0, leadMan=0, error=+5 for 4 consecutive clocks -> lagAccum 10,20,30,40. Then acqTrackControl=01 freezes it at 40. clearAccum=1 for 1 clock -> 0 on the next edge.
- Limits: upperLimit=100, lowerLimit=-50, lagMan=1, error=+60 x3 -> lagAccum 60,100,100. Then error=-200 x1 -> -50.
- Saturation: error=2047, leadMan=255, leadExp=31, upperLimit=0x7FFFFFFF -> loopOut=0x7FFFFFFF. error=-2048 with invertError=1 -> condErr=+2047, same result.
- Lock hysteresis: syncThreshold=16, lockCount=4, error=3 x4 -> lockStatus rises 2 clocks after the 4th sample. Then error=100 x3 -> stays 1; 4th -> falls. Repeat with lockCount=0 -> lockStatus stays 0.
